ori_clkgen: RTL

Clock-phase and CPU-control generator for the Orion-128 KR580VM80A core. It derives the φ1/φ2 two-phase CPU clock from the single system clock as levels and one-cycle enable strobes, in the manner of the 8224. It also produces the status strobe, the synchronized READY, and the stretched CPU reset. Its `cpu_f1_o` and `cpu_ststb_o` feed the M1/status decode stage directly downstream.

---
 rtl/ori_clkgen.sv | 96 +++++++++
 1 files changed

// File: rtl/ori_clkgen.sv
// Two-phase CPU clock and control generator for the KR580VM80A core (8224-style).
// All outputs are flops loaded from a decode of the next phase value.
module ori_clkgen #(
    parameter int PERIOD     = 9,
    parameter int F1_LEN     = 2,
    parameter int F2_LEN     = 5,
    parameter int RESET_HOLD = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic cpu_sync_i,
    input  logic rdyin_i,
    input  logic resin_i,
    output logic cpu_phi1_o,
    output logic cpu_phi2_o,
    output logic cpu_f1_o,
    output logic cpu_f2_o,
    output logic cpu_ststb_o,
    output logic cpu_ready_o,
    output logic cpu_reset_o
);

    localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int HW = $clog2(RESET_HOLD + 1);

    localparam logic [PW-1:0] PH_LAST   = PW'(PERIOD - 1);
    localparam logic [PW-1:0] PH_F2     = PW'(F1_LEN);
    localparam logic [PW-1:0] PH_GAP    = PW'(F1_LEN + F2_LEN);
    localparam logic [HW-1:0] HOLD_INIT = HW'(RESET_HOLD);

    logic [PW-1:0] ph;
    logic [PW-1:0] ph_n;
    logic [HW-1:0] hc;
    logic [HW-1:0] hc_n;
    logic          rdy_m;
    logic          rdy_s;
    logic          res_m;
    logic          res_s;

    // Next phase value and next hold count; the hold count ticks once per CPU period.
    always_comb begin
        ph_n = ph;
        hc_n = hc;
        if (ph == PH_LAST) begin
            ph_n = '0;
        end else begin
            ph_n = ph + PW'(1);
        end
        if (res_s) begin
            hc_n = HOLD_INIT;
        end else if ((ph_n == '0) && (hc != '0)) begin
            hc_n = hc - HW'(1);
        end else begin
            hc_n = hc;
        end
    end

    // Phase counter, synchronizers, hold counter and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ph          <= PH_LAST;
            hc          <= HOLD_INIT;
            rdy_m       <= 1'b0;
            rdy_s       <= 1'b0;
            res_m       <= 1'b0;
            res_s       <= 1'b0;
            cpu_phi1_o  <= 1'b0;
            cpu_phi2_o  <= 1'b0;
            cpu_f1_o    <= 1'b0;
            cpu_f2_o    <= 1'b0;
            cpu_ststb_o <= 1'b0;
            cpu_ready_o <= 1'b0;
            cpu_reset_o <= 1'b1;
        end else begin
            ph          <= ph_n;
            hc          <= hc_n;
            rdy_m       <= rdyin_i;
            rdy_s       <= rdy_m;
            res_m       <= resin_i;
            res_s       <= res_m;
            cpu_phi1_o  <= (ph_n < PH_F2);
            cpu_phi2_o  <= (ph_n >= PH_F2) && (ph_n < PH_GAP);
            cpu_f1_o    <= (ph_n == '0);
            cpu_f2_o    <= (ph_n == PH_F2);
            cpu_ststb_o <= (ph_n == '0) & cpu_sync_i;
            if (ph_n == PH_F2) begin
                cpu_ready_o <= rdy_s;
            end else begin
                cpu_ready_o <= cpu_ready_o;
            end
            // res_m is the value res_s takes at this edge, so the output tracks the new state.
            cpu_reset_o <= res_m | (hc_n != '0);
        end
    end

endmodule
